// File: rtl/m68k_bus_target_pkg.sv
// Shared definitions for the 68000 bus responder: controller states,
// function-code and RW encodings, and the data-strobe to byte-enable mapping.
package m68k_bus_target_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_DS,
    REQ,
    WAIT,
    ACK,
    ERR
  } state_t;

  localparam logic [2:0] FC_IACK  = 3'b111;
  localparam logic       RW_READ  = 1'b1;
  localparam logic       RW_WRITE = 1'b0;

  // Active-low data strobes map to {upper, lower} byte enables.
  function automatic logic [1:0] strobe_be(input logic uds_n, input logic lds_n);
    return {~uds_n, ~lds_n};
  endfunction

endpackage

// File: rtl/m68k_bus_target.sv
// 68000 bus responder. Decodes initiator cycles that fall inside the
// BASE/MASK address window and forwards them to a local word store over a
// level req / pulse ack port, then answers the bus with DTACK_n (after
// WAIT_STATES extra clocks) or BERR_n when the store does not answer within
// TIMEOUT clocks.
//
// Ports:
//   M68K_CLK, M68K_RESET_n   clock, synchronous active-low reset
//   M68K_A/FC/AS_n/UDS_n/LDS_n/RW/D_IN   initiator bus inputs (registered once)
//   M68K_D_OUT, M68K_D_OE    read data and its output enable (tristate lives above)
//   M68K_DTACK_n, M68K_BERR_n  cycle termination
//   mem_req/we/addr/be/wdata  request to local store, held until mem_ack
//   mem_ack, mem_rdata        one-cycle completion with read data
//   busy                      high whenever the controller is not IDLE
module m68k_bus_target
  import m68k_bus_target_pkg::*;
#(
  parameter logic [22:0] BASE        = 23'h7C0000,
  parameter logic [22:0] MASK        = 23'h7F0000,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic              M68K_CLK,
  input  logic              M68K_RESET_n,
  input  logic [22:0]       M68K_A,
  input  logic [2:0]        M68K_FC,
  input  logic              M68K_AS_n,
  input  logic              M68K_UDS_n,
  input  logic              M68K_LDS_n,
  input  logic              M68K_RW,
  input  logic [15:0]       M68K_D_IN,
  output logic [15:0]       M68K_D_OUT,
  output logic              M68K_D_OE,
  output logic              M68K_DTACK_n,
  output logic              M68K_BERR_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_be,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              busy
);

  localparam logic [3:0] WS      = 4'(WAIT_STATES);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [22:0] a_q;
  logic [2:0]  fc_q;
  logic        as_q, uds_q, lds_q, rw_q;
  logic [15:0] d_q;

  state_t      state;
  logic [3:0]  wcnt;
  logic [7:0]  to_cnt;
  logic        armed;
  logic        hit;
  logic        timed_out;

  // Single synchronising stage on every bus input; all decisions use these.
  always_ff @(posedge M68K_CLK) begin
    a_q   <= M68K_A;
    fc_q  <= M68K_FC;
    as_q  <= M68K_AS_n;
    uds_q <= M68K_UDS_n;
    lds_q <= M68K_LDS_n;
    rw_q  <= M68K_RW;
    d_q   <= M68K_D_IN;
  end

  assign hit       = (a_q & MASK) == BASE;
  assign timed_out = to_cnt >= TO_LAST;
  assign busy      = (state != IDLE);

  always_ff @(posedge M68K_CLK) begin
    if (!M68K_RESET_n) begin
      state        <= IDLE;
      M68K_DTACK_n <= 1'b1;
      M68K_BERR_n  <= 1'b1;
      M68K_D_OE    <= 1'b0;
      M68K_D_OUT   <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      wcnt         <= '0;
      to_cnt       <= '0;
      armed        <= 1'b0;
    end else begin
      // A cycle is only accepted after AS has been seen negated, so a cycle
      // already in progress at reset release (or just served) is not re-taken.
      if (as_q) armed <= 1'b1;
      if (state == WR_DS || state == REQ || state == WAIT) to_cnt <= to_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (!as_q && armed && hit && fc_q != FC_IACK) begin
            armed    <= 1'b0;
            to_cnt   <= '0;
            mem_addr <= a_q[ADDR_W-1:0];
            mem_we   <= (rw_q == RW_WRITE);
            if (rw_q == RW_READ) begin
              mem_be  <= strobe_be(uds_q, lds_q);
              mem_req <= 1'b1;
              state   <= REQ;
            end else begin
              state <= WR_DS;
            end
          end
        end

        WR_DS: begin
          if (as_q) begin
            state <= IDLE;
          end else if (!uds_q || !lds_q) begin
            mem_be    <= strobe_be(uds_q, lds_q);
            mem_wdata <= d_q;
            mem_req   <= 1'b1;
            state     <= REQ;
          end else if (timed_out) begin
            M68K_BERR_n <= 1'b0;
            state       <= ERR;
          end
        end

        REQ: begin
          // Abort has priority over a coincident ack; ack beats timeout.
          if (as_q) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (mem_ack) begin
            mem_req    <= 1'b0;
            M68K_D_OUT <= mem_rdata;
            if (WS == 4'd0) begin
              M68K_DTACK_n <= 1'b0;
              M68K_D_OE    <= ~mem_we;
              state        <= ACK;
            end else begin
              wcnt  <= WS;
              state <= WAIT;
            end
          end else if (timed_out) begin
            mem_req     <= 1'b0;
            M68K_BERR_n <= 1'b0;
            state       <= ERR;
          end
        end

        WAIT: begin
          if (as_q) begin
            state <= IDLE;
          end else if (wcnt == 4'd1) begin
            M68K_DTACK_n <= 1'b0;
            M68K_D_OE    <= ~mem_we;
            state        <= ACK;
          end else if (timed_out) begin
            M68K_BERR_n <= 1'b0;
            state       <= ERR;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end

        ACK: begin
          if (as_q) begin
            M68K_DTACK_n <= 1'b1;
            M68K_D_OE    <= 1'b0;
            state        <= IDLE;
          end
        end

        ERR: begin
          if (as_q) begin
            M68K_BERR_n <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_bus_target.sv
// Directed bench for m68k_bus_target: a vector table of complete bus cycles
// against a zero-wait-state instance, plus hand sequences for wait states,
// delayed write strobes, timeout, abort and reset during acknowledge. A second
// instance with three wait states shares all inputs.
module tb_m68k_bus_target;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [22:0] a;
  logic [2:0]  fc;
  logic        as_n, uds_n, lds_n, rw;
  logic [15:0] din;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  logic [15:0] d_out0, d_out3;
  logic        d_oe0, d_oe3, dtack0, dtack3, berr0, berr3;
  logic        req0, req3, we0, we3, busy0, busy3;
  logic [15:0] addr0, addr3, wdata0, wdata3;
  logic [1:0]  be0, be3;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  m68k_bus_target #(.WAIT_STATES(0), .TIMEOUT(TMO)) dut0 (
    .M68K_CLK(clk), .M68K_RESET_n(rst_n), .M68K_A(a), .M68K_FC(fc),
    .M68K_AS_n(as_n), .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw),
    .M68K_D_IN(din), .M68K_D_OUT(d_out0), .M68K_D_OE(d_oe0),
    .M68K_DTACK_n(dtack0), .M68K_BERR_n(berr0), .mem_req(req0), .mem_we(we0),
    .mem_addr(addr0), .mem_be(be0), .mem_wdata(wdata0), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy0));

  m68k_bus_target #(.WAIT_STATES(3), .TIMEOUT(TMO)) dut3 (
    .M68K_CLK(clk), .M68K_RESET_n(rst_n), .M68K_A(a), .M68K_FC(fc),
    .M68K_AS_n(as_n), .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw),
    .M68K_D_IN(din), .M68K_D_OUT(d_out3), .M68K_D_OE(d_oe3),
    .M68K_DTACK_n(dtack3), .M68K_BERR_n(berr3), .mem_req(req3), .mem_we(we3),
    .mem_addr(addr3), .mem_be(be3), .mem_wdata(wdata3), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy3));

  typedef struct {
    logic [22:0] a;
    logic [2:0]  fc;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [15:0] din;
    logic [15:0] rdata;
    int          ack_dly;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic [1:0]  exp_be;
    logic        exp_we;
    logic [15:0] exp_wdata;
    logic        exp_oe;
    logic [15:0] exp_dout;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    as_n  = 1'b1;
    uds_n = 1'b1;
    lds_n = 1'b1;
    rw    = 1'b1;
  endtask

  task automatic wait_req0(input int budget, output logic got);
    got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (req0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic got;
    a = v.a; fc = v.fc; rw = v.rw; uds_n = v.uds_n; lds_n = v.lds_n; din = v.din;
    as_n = 1'b0;
    wait_req0(8, got);
    check("req_seen", 32'(got), 32'(v.exp_req));
    if (got) begin
      check("mem_addr", 32'(addr0), 32'(v.exp_addr));
      check("mem_be", 32'(be0), 32'(v.exp_be));
      check("mem_we", 32'(we0), 32'(v.exp_we));
      if (v.exp_we) check("mem_wdata", 32'(wdata0), 32'(v.exp_wdata));
      repeat (v.ack_dly) tick();
      mem_rdata = v.rdata;
      mem_ack   = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("dtack_low", 32'(dtack0), 32'd0);
      check("req_dropped", 32'(req0), 32'd0);
      check("d_oe", 32'(d_oe0), 32'(v.exp_oe));
      check("berr_high", 32'(berr0), 32'd1);
      if (v.exp_oe) check("d_out", 32'(d_out0), 32'(v.exp_dout));
    end else begin
      check("miss_dtack", 32'(dtack0), 32'd1);
      check("miss_berr", 32'(berr0), 32'd1);
      check("miss_oe", 32'(d_oe0), 32'd0);
      check("miss_busy", 32'(busy0), 32'd0);
    end
    bus_idle();
    tick();
    tick();
    check("end_dtack", 32'(dtack0), 32'd1);
    check("end_oe", 32'(d_oe0), 32'd0);
    check("end_busy", 32'(busy0), 32'd0);
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic got;
    int   cnt;
    vec_t v;

    //          a         fc      rw    uds   lds   din       rdata    dly req  addr      be     we    wdata     oe    dout
    vecs[0] = '{23'h7C0010, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 2, 1'b1, 16'h0010, 2'b11, 1'b0, 16'h0000, 1'b1, 16'hBEEF};
    vecs[1] = '{23'h7C0123, 3'b001, 1'b0, 1'b1, 1'b0, 16'h00A5, 16'h0000, 1, 1'b1, 16'h0123, 2'b01, 1'b1, 16'h00A5, 1'b0, 16'h0000};
    vecs[2] = '{23'h7CFFFF, 3'b001, 1'b0, 1'b0, 1'b1, 16'h5A00, 16'h0000, 0, 1'b1, 16'hFFFF, 2'b10, 1'b1, 16'h5A00, 1'b0, 16'h0000};
    vecs[3] = '{23'h7C8000, 3'b101, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234, 1, 1'b1, 16'h8000, 2'b01, 1'b0, 16'h0000, 1'b1, 16'h1234};
    vecs[4] = '{23'h100000, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1111, 0, 1'b0, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[5] = '{23'h7D0010, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1111, 0, 1'b0, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[6] = '{23'h7BFFFF, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1111, 0, 1'b0, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[7] = '{23'h7C0010, 3'b111, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1111, 0, 1'b0, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[8] = '{23'h7CFFFE, 3'b110, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hA55A, 0, 1'b1, 16'hFFFE, 2'b11, 1'b0, 16'h0000, 1'b1, 16'hA55A};
    vecs[9] = '{23'h7C0002, 3'b001, 1'b0, 1'b0, 1'b0, 16'h1357, 16'h0000, 3, 1'b1, 16'h0002, 2'b11, 1'b1, 16'h1357, 1'b0, 16'h0000};

    rst_n = 1'b0;
    a = '0; fc = 3'b101; din = '0; mem_ack = 1'b0; mem_rdata = '0;
    bus_idle();
    repeat (3) tick();
    check("rst_dtack", 32'(dtack0), 32'd1);
    check("rst_berr", 32'(berr0), 32'd1);
    check("rst_oe", 32'(d_oe0), 32'd0);
    check("rst_dout", 32'(d_out0), 32'd0);
    check("rst_req", 32'(req0), 32'd0);
    check("rst_we", 32'(we0), 32'd0);
    check("rst_be", 32'(be0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Write with late data strobe, observed on the three-wait-state instance.
    a = 23'h7C0040; fc = 3'b001; rw = 1'b0; din = 16'h00A5; as_n = 1'b0;
    repeat (3) tick();
    check("wrds_busy", 32'(busy0), 32'd1);
    check("wrds_noreq", 32'(req0), 32'd0);
    lds_n = 1'b0;
    wait_req0(6, got);
    check("ws_req_seen", 32'(got), 32'd1);
    check("ws_req3", 32'(req3), 32'd1);
    check("ws_we", 32'(we3), 32'd1);
    check("ws_be", 32'(be3), 32'b01);
    check("ws_wdata", 32'(wdata3), 32'h00A5);
    check("ws_addr", 32'(addr3), 32'h0040);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("ws0_dtack_now", 32'(dtack0), 32'd0);
    check("ws3_dtack_ack", 32'(dtack3), 32'd1);
    check("ws3_req_drop", 32'(req3), 32'd0);
    repeat (2) tick();
    check("ws3_dtack_ack2", 32'(dtack3), 32'd1);
    tick();
    check("ws3_dtack_ack3", 32'(dtack3), 32'd0);
    check("ws3_oe_write", 32'(d_oe3), 32'd0);
    bus_idle();
    repeat (2) tick();
    check("ws3_dtack_end", 32'(dtack3), 32'd1);
    check("ws3_busy_end", 32'(busy3), 32'd0);
    tick();

    // Timeout: store never answers.
    a = 23'h7C0200; fc = 3'b101; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    wait_req0(8, got);
    check("to_req_seen", 32'(got), 32'd1);
    cnt = 0;
    for (int k = 0; k < 3 * TMO; k++) begin
      tick();
      cnt++;
      if (!berr0) break;
    end
    check("to_latency", 32'(cnt), 32'(TMO));
    check("to_berr", 32'(berr0), 32'd0);
    check("to_req", 32'(req0), 32'd0);
    check("to_dtack", 32'(dtack0), 32'd1);
    bus_idle();
    tick();
    check("to_berr_hold", 32'(berr0), 32'd0);
    tick();
    check("to_berr_rel", 32'(berr0), 32'd1);
    check("to_busy", 32'(busy0), 32'd0);
    tick();

    // Abort in REQ with a coincident ack that must be dropped.
    a = 23'h7C0300; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    wait_req0(8, got);
    check("ab_req_seen", 32'(got), 32'd1);
    bus_idle();
    tick();
    check("ab_req_hold", 32'(req0), 32'd1);
    mem_rdata = 16'hDEAD;
    mem_ack   = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("ab_req_drop", 32'(req0), 32'd0);
    check("ab_busy", 32'(busy0), 32'd0);
    check("ab_dtack", 32'(dtack0), 32'd1);
    repeat (2) tick();
    check("ab_dtack_late", 32'(dtack0), 32'd1);
    check("ab_oe", 32'(d_oe0), 32'd0);
    v = vecs[0];
    v.a = 23'h7C0301; v.rdata = 16'h4321; v.exp_addr = 16'h0301; v.exp_dout = 16'h4321;
    run_vec(v);

    // Reset while DTACK is asserted.
    a = 23'h7C0010; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    wait_req0(8, got);
    mem_rdata = 16'h7777;
    mem_ack   = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("rs_pre_dtack", 32'(dtack0), 32'd0);
    rst_n = 1'b0;
    tick();
    check("rs_dtack", 32'(dtack0), 32'd1);
    check("rs_oe", 32'(d_oe0), 32'd0);
    check("rs_busy", 32'(busy0), 32'd0);
    check("rs_dout", 32'(d_out0), 32'd0);
    check("rs_berr", 32'(berr0), 32'd1);
    rst_n = 1'b1;
    bus_idle();
    repeat (2) tick();
    run_vec(vecs[7]);
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
